// File: rtl/frame_cfg_pkg.sv
// frame_cfg_pkg
//   Shared definitions for the column configuration-frame loader:
//   header sync/field positions, FSM state encoding, CRC-16-CCITT
//   constants and a one-word CRC update helper.
//   The CRC items are only referenced when FRAME_CRC_EN is defined.
package frame_cfg_pkg;

  localparam logic [7:0]  HDR_SYNC     = 8'hA5;
  localparam int          HDR_SYNC_MSB = 31;
  localparam int          HDR_SYNC_LSB = 24;
  localparam int          HDR_IDX_MSB  = 4;
  localparam int          HDR_IDX_LSB  = 0;
  localparam int          HDR_IDX_W    = HDR_IDX_MSB - HDR_IDX_LSB + 1;

  localparam logic [15:0] CRC16_POLY   = 16'h1021;
  localparam logic [15:0] CRC16_INIT   = 16'hFFFF;

  typedef enum logic [2:0] {
    ST_HDR    = 3'd0,
    ST_LOAD   = 3'd1,
    ST_CHK    = 3'd2,
    ST_STROBE = 3'd3,
    ST_GAP    = 3'd4
  } frame_state_e;

  // Advance a CRC-16-CCITT over one 32-bit word, MSB first.
  function automatic logic [15:0] crc16_word(input logic [15:0] crc_in,
                                             input logic [31:0] data);
    logic [15:0] c;
    c = crc_in;
    for (int i = 31; i >= 0; i--) begin
      if ((c[15] ^ data[i]) == 1'b1) begin
        c = {c[14:0], 1'b0} ^ CRC16_POLY;
      end else begin
        c = {c[14:0], 1'b0};
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/frame_crc16.sv
// frame_crc16
//   Running CRC-16-CCITT over a stream of 32-bit words, one word per cycle.
//   Ports:
//     clk, rst_n  clock / async active-low reset (CRC returns to init value)
//     clr         load the init value (start of a new frame)
//     en          fold data into the CRC this cycle
//     data        32-bit word
//     crc         current CRC value (registered)
//   Only instantiated when FRAME_CRC_EN is defined.
module frame_crc16
  import frame_cfg_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        en,
  input  logic [31:0] data,
  output logic [15:0] crc
);

  logic [15:0] crc_r;

  // CRC accumulator; clear has priority over a data update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc_r <= CRC16_INIT;
    end else if (clr) begin
      crc_r <= CRC16_INIT;
    end else if (en) begin
      crc_r <= crc16_word(crc_r, data);
    end
  end

  assign crc = crc_r;

endmodule

// File: rtl/frame_strobe_sequencer.sv
// frame_strobe_sequencer
//   Loads one configuration frame for a fabric column from a word stream
//   (header + NumRows data words), assembles the full-column FrameData
//   vector and then pulses exactly one FrameStrobe line for STROBE_CYCLES
//   cycles, followed by a one-cycle gap.
//   Optional build macro: FRAME_CRC_EN adds a CHK state that takes one
//   trailer word whose [15:0] must match a CRC-16-CCITT of the data words.
//   Ports:
//     UserCLK, resetn  clock / async active-low reset
//     s_data, s_valid  input stream word and its valid
//     s_ready          word accepted when s_valid & s_ready (registered)
//     FrameData        row k at [k*FrameBitsPerRow +: FrameBitsPerRow]
//     FrameStrobe      one-hot frame strobe, zero when not strobing
//     busy             high whenever the FSM is not waiting for a header
//     frames_done      wrapping count of frames strobed since reset
//     err_sticky       header/CRC error seen; err_clr clears it
module frame_strobe_sequencer
  import frame_cfg_pkg::*;
#(
  parameter int FrameBitsPerRow = 32,
  parameter int MaxFramesPerCol = 20,
  parameter int NumRows         = 4,
  parameter int STROBE_CYCLES   = 2
)
(
  input  logic                                 UserCLK,
  input  logic                                 resetn,
  input  logic [FrameBitsPerRow-1:0]           s_data,
  input  logic                                 s_valid,
  output logic                                 s_ready,
  output logic [NumRows*FrameBitsPerRow-1:0]   FrameData,
  output logic [MaxFramesPerCol-1:0]           FrameStrobe,
  output logic                                 busy,
  output logic [15:0]                          frames_done,
  output logic                                 err_sticky,
  input  logic                                 err_clr
);

  localparam int RowW = (NumRows > 1) ? $clog2(NumRows) : 1;
  localparam int StbW = (STROBE_CYCLES > 1) ? $clog2(STROBE_CYCLES) : 1;
  localparam logic [RowW-1:0] LastRow = RowW'(NumRows - 1);
  localparam logic [StbW-1:0] LastStb = StbW'(STROBE_CYCLES - 1);

  frame_state_e                        state_r, next_state_s;
  logic [RowW-1:0]                     row_cnt_r;
  logic [StbW-1:0]                     stb_cnt_r;
  logic [HDR_IDX_W-1:0]                idx_r;
  logic                                drop_r;
  logic [NumRows*FrameBitsPerRow-1:0]  frame_data_r;
  logic [MaxFramesPerCol-1:0]          strobe_r;
  logic [MaxFramesPerCol-1:0]          strobe_dec_s;
  logic                                s_ready_r;
  logic                                busy_r;
  logic [15:0]                         frames_done_r;
  logic                                err_r;

  logic accept_s;
  logic hdr_ok_s;
  logic hdr_acc_s;
  logic row_wr_s;
  logic set_err_s;
  logic frame_end_s;

  assign accept_s = s_valid & s_ready_r;
  assign hdr_ok_s = (s_data[HDR_SYNC_MSB:HDR_SYNC_LSB] == HDR_SYNC) &&
                    ({27'd0, s_data[HDR_IDX_MSB:HDR_IDX_LSB]} < 32'(MaxFramesPerCol));

`ifdef FRAME_CRC_EN
  logic [15:0] crc_s;

  // The CRC restarts on every accepted header and folds in each LOAD word.
  frame_crc16 u_crc (
    .clk   (UserCLK),
    .rst_n (resetn),
    .clr   (hdr_acc_s),
    .en    ((state_r == ST_LOAD) && accept_s),
    .data  (s_data),
    .crc   (crc_s)
  );
`endif

  // Next-state and per-cycle control decode.
  always_comb begin
    next_state_s = state_r;
    hdr_acc_s    = 1'b0;
    row_wr_s     = 1'b0;
    set_err_s    = 1'b0;
    frame_end_s  = 1'b0;
    case (state_r)
      ST_HDR: begin
        if (accept_s) begin
          // Bad headers still enter LOAD so their data words are swallowed.
          next_state_s = ST_LOAD;
          hdr_acc_s    = 1'b1;
          set_err_s    = ~hdr_ok_s;
        end else begin
          next_state_s = ST_HDR;
        end
      end
      ST_LOAD: begin
        if (accept_s) begin
          row_wr_s = ~drop_r;
          if (row_cnt_r == LastRow) begin
`ifdef FRAME_CRC_EN
            next_state_s = ST_CHK;
`else
            next_state_s = drop_r ? ST_HDR : ST_STROBE;
`endif
          end else begin
            next_state_s = ST_LOAD;
          end
        end else begin
          next_state_s = ST_LOAD;
        end
      end
`ifdef FRAME_CRC_EN
      ST_CHK: begin
        if (accept_s) begin
          if (drop_r) begin
            next_state_s = ST_HDR;
          end else if (s_data[15:0] == crc_s) begin
            next_state_s = ST_STROBE;
          end else begin
            next_state_s = ST_HDR;
            set_err_s    = 1'b1;
          end
        end else begin
          next_state_s = ST_CHK;
        end
      end
`endif
      ST_STROBE: begin
        if (stb_cnt_r == LastStb) begin
          next_state_s = ST_GAP;
          frame_end_s  = 1'b1;
        end else begin
          next_state_s = ST_STROBE;
        end
      end
      ST_GAP: begin
        next_state_s = ST_HDR;
      end
      default: begin
        next_state_s = ST_HDR;
      end
    endcase
  end

  // One-hot decode of the captured frame index.
  always_comb begin
    strobe_dec_s = '0;
    for (int i = 0; i < MaxFramesPerCol; i++) begin
      if (idx_r == HDR_IDX_W'(i)) begin
        strobe_dec_s[i] = 1'b1;
      end else begin
        strobe_dec_s[i] = 1'b0;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge UserCLK or negedge resetn) begin
    if (!resetn) begin
      state_r <= ST_HDR;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Header capture (index, drop flag) and data-row counter.
  always_ff @(posedge UserCLK or negedge resetn) begin
    if (!resetn) begin
      idx_r     <= '0;
      drop_r    <= 1'b0;
      row_cnt_r <= '0;
    end else if (hdr_acc_s) begin
      idx_r     <= s_data[HDR_IDX_MSB:HDR_IDX_LSB];
      drop_r    <= ~hdr_ok_s;
      row_cnt_r <= '0;
    end else if ((state_r == ST_LOAD) && accept_s) begin
      row_cnt_r <= (row_cnt_r == LastRow) ? '0 : row_cnt_r + RowW'(1);
    end
  end

  // Strobe-length counter, running only while in STROBE.
  always_ff @(posedge UserCLK or negedge resetn) begin
    if (!resetn) begin
      stb_cnt_r <= '0;
    end else if ((state_r == ST_STROBE) && (stb_cnt_r != LastStb)) begin
      stb_cnt_r <= stb_cnt_r + StbW'(1);
    end else begin
      stb_cnt_r <= '0;
    end
  end

  // FrameData bank: written only by LOAD words of a good frame, so it is
  // stable across the whole strobe and gap.
  always_ff @(posedge UserCLK or negedge resetn) begin
    if (!resetn) begin
      frame_data_r <= '0;
    end else begin
      for (int k = 0; k < NumRows; k++) begin
        if (row_wr_s && (row_cnt_r == RowW'(k))) begin
          frame_data_r[k*FrameBitsPerRow +: FrameBitsPerRow] <= s_data;
        end
      end
    end
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge UserCLK or negedge resetn) begin
    if (!resetn) begin
      s_ready_r <= 1'b1;
      busy_r    <= 1'b0;
      strobe_r  <= '0;
    end else begin
      s_ready_r <= (next_state_s == ST_HDR) || (next_state_s == ST_LOAD) ||
                   (next_state_s == ST_CHK);
      busy_r    <= (next_state_s != ST_HDR);
      strobe_r  <= (next_state_s == ST_STROBE) ? strobe_dec_s : '0;
    end
  end

  // Completed-frame counter; becomes visible in the GAP cycle.
  always_ff @(posedge UserCLK or negedge resetn) begin
    if (!resetn) begin
      frames_done_r <= 16'd0;
    end else if (frame_end_s) begin
      frames_done_r <= frames_done_r + 16'd1;
    end
  end

  // Sticky error flag; a new error beats a simultaneous clear.
  always_ff @(posedge UserCLK or negedge resetn) begin
    if (!resetn) begin
      err_r <= 1'b0;
    end else if (set_err_s) begin
      err_r <= 1'b1;
    end else if (err_clr) begin
      err_r <= 1'b0;
    end
  end

  assign s_ready     = s_ready_r;
  assign FrameData   = frame_data_r;
  assign FrameStrobe = strobe_r;
  assign busy        = busy_r;
  assign frames_done = frames_done_r;
  assign err_sticky  = err_r;

endmodule

// File: tb/tb_frame_strobe_sequencer.sv
module tb_frame_strobe_sequencer;

  localparam int W  = 32;
  localparam int NF = 20;
  localparam int NR = 4;
  localparam int SC = 2;

  logic              UserCLK = 1'b0;
  logic              resetn  = 1'b0;
  logic [W-1:0]      s_data  = '0;
  logic              s_valid = 1'b0;
  logic              err_clr = 1'b0;
  logic              s_ready;
  logic [NR*W-1:0]   FrameData;
  logic [NF-1:0]     FrameStrobe;
  logic              busy;
  logic [15:0]       frames_done;
  logic              err_sticky;

  frame_strobe_sequencer #(
    .FrameBitsPerRow(W), .MaxFramesPerCol(NF), .NumRows(NR), .STROBE_CYCLES(SC)
  ) dut (
    .UserCLK(UserCLK), .resetn(resetn), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready), .FrameData(FrameData), .FrameStrobe(FrameStrobe),
    .busy(busy), .frames_done(frames_done), .err_sticky(err_sticky),
    .err_clr(err_clr)
  );

  always #5 UserCLK = ~UserCLK;

  int cyc = 0;
  always @(posedge UserCLK) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [NF-1:0]   strb;
    logic [NR*W-1:0] fd;
    int              at;
  } exp_t;
  exp_t sb_q[$];

  logic [NR*W-1:0] exp_fd   = '0;
  logic [15:0]     exp_done = 16'd0;
  logic            exp_err  = 1'b0;
  int              lat_base = 0;

`ifdef FRAME_CRC_EN
  function automatic logic [15:0] tb_crc(input logic [NR*W-1:0] words);
    logic [15:0] c;
    logic        fb;
    c = 16'hFFFF;
    for (int r = 0; r < NR; r++) begin
      for (int b = W - 1; b >= 0; b--) begin
        fb = c[15] ^ words[r*W + b];
        c  = {c[14:0], 1'b0};
        if (fb) c = c ^ 16'h1021;
      end
    end
    return c;
  endfunction
`endif

  // Present one word from a negedge and hold it until accepted.
  task automatic send_word(input logic [W-1:0] d, output int acc);
    bit ok;
    ok = 1'b0;
    @(negedge UserCLK);
    s_data  = d;
    s_valid = 1'b1;
    for (int k = 0; k < 64; k++) begin
      if (s_ready === 1'b1) begin
        @(posedge UserCLK);
        ok = 1'b1;
        break;
      end
      @(negedge UserCLK);
    end
    #1;
    s_valid = 1'b0;
    acc = cyc;
    if (!ok) begin
      checks++; errors++;
      $display("FAIL accept_timeout word=%h s_ready=%b required 1", d, s_ready);
    end
  endtask

  // Send header + data (+ trailer) and record the scoreboard expectations.
  task automatic send_frame(input logic [W-1:0] hdr, input logic [NR*W-1:0] words,
                            input int gap, input bit flip, input bit push,
                            output int hdr_cyc, output int last_cyc);
    bit good;
    bit crc_ok;
    logic [NF-1:0] strb;
`ifdef FRAME_CRC_EN
    logic [15:0] c;
`endif
    send_word(hdr, hdr_cyc);
    for (int k = 0; k < NR; k++) begin
      if (k == 2 && gap > 0) repeat (gap) @(posedge UserCLK);
      send_word(words[k*W +: W], last_cyc);
    end
    crc_ok = 1'b1;
`ifdef FRAME_CRC_EN
    c = tb_crc(words);
    if (flip) c = c ^ 16'h0001;
    crc_ok = ~flip;
    send_word({16'h0000, c}, last_cyc);
`endif
    good = (hdr[31:24] == 8'hA5) && (hdr[4:0] < 5'd20);
    if (good) exp_fd = words;
    if (!good || !crc_ok) exp_err = 1'b1;
    if (good && crc_ok) begin
      exp_done = exp_done + 16'd1;
      strb = '0;
      strb[hdr[4:0]] = 1'b1;
      if (push) begin
        for (int i = 0; i < SC; i++) sb_q.push_back('{strb, words, last_cyc + i});
      end
    end
  endtask

  // Watch FrameStrobe for n cycles and retire scoreboard entries.
  task automatic collect(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      @(negedge UserCLK);
      if (FrameStrobe !== '0) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_strobe cyc=%0d got=%h required 0", cyc, FrameStrobe);
        end else begin
          e = sb_q.pop_front();
          if (FrameStrobe !== e.strb || cyc != e.at || FrameData !== e.fd) begin
            errors++;
            $display("FAIL strobe cyc=%0d got=%h data=%h required cyc=%0d strobe=%h data=%h",
                     cyc, FrameStrobe, FrameData, e.at, e.strb, e.fd);
          end
        end
      end else if (sb_q.size() != 0 && sb_q[0].at <= cyc) begin
        checks++; errors++;
        $display("FAIL missing_strobe cyc=%0d got=0 required %h", cyc, sb_q[0].strb);
        void'(sb_q.pop_front());
      end
    end
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL leftover_strobes got=%0d pending required 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic check_status(input string name);
    checks++;
    if (FrameData !== exp_fd || frames_done !== exp_done || err_sticky !== exp_err) begin
      errors++;
      $display("FAIL %s data=%h done=%0d err=%b required data=%h done=%0d err=%b", name,
               FrameData, frames_done, err_sticky, exp_fd, exp_done, exp_err);
    end
  endtask

  task automatic clear_err();
    @(negedge UserCLK); err_clr = 1'b1;
    @(negedge UserCLK); err_clr = 1'b0;
    exp_err = 1'b0;
    checks++;
    if (err_sticky !== 1'b0) begin
      errors++;
      $display("FAIL err_clr got=%b required 0", err_sticky);
    end
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if (s_ready !== 1'b1 || busy !== 1'b0 || FrameStrobe !== '0 || FrameData !== '0 ||
        frames_done !== 16'd0 || err_sticky !== 1'b0) begin
      errors++;
      $display("FAIL reset_state rdy=%b busy=%b strb=%h data=%h done=%0d err=%b required 1 0 0 0 0 0",
               s_ready, busy, FrameStrobe, FrameData, frames_done, err_sticky);
    end
    @(negedge UserCLK); resetn = 1'b1;
  endtask

  task automatic test_basic();
    int h, l;
    send_frame(32'hA500_0003, {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111},
               0, 1'b0, 1'b1, h, l);
    lat_base = l - h;
    collect(2);
    @(negedge UserCLK);
    checks++;
    if (cyc != l + 2 || FrameStrobe !== '0 || s_ready !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL gap_cycle cyc=%0d strb=%h rdy=%b busy=%b required cyc=%0d 0 0 1",
               cyc, FrameStrobe, s_ready, busy, l + 2);
    end
    @(negedge UserCLK);
    checks++;
    if (s_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL ready_after_gap rdy=%b busy=%b required 1 0", s_ready, busy);
    end
    check_status("basic_status");
  endtask

  task automatic test_bad_index();
    int h, l;
    send_frame(32'hA500_0014, {4{32'hDEAD_BEEF}}, 0, 1'b0, 1'b1, h, l);
    collect(6);
    check_status("bad_index_status");
    clear_err();
  endtask

  task automatic test_bad_sync();
    int h, l;
    send_frame(32'h5A00_0001, {4{32'hCAFE_F00D}}, 0, 1'b0, 1'b1, h, l);
    send_frame(32'hA500_0000, {32'h0404_0404, 32'h0303_0303, 32'h0202_0202, 32'h0101_0101},
               0, 1'b0, 1'b1, h, l);
    collect(6);
    check_status("bad_sync_status");
    clear_err();
  endtask

  task automatic test_stall();
    int h, l;
    send_frame(32'hA500_0003, {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111},
               5, 1'b0, 1'b1, h, l);
    checks++;
    if (l - h != lat_base + 5) begin
      errors++;
      $display("FAIL stall_latency got=%0d required %0d", l - h, lat_base + 5);
    end
    collect(6);
    check_status("stall_status");
  endtask

  task automatic test_back_to_back();
    int h1, l1, h2, l2;
    send_frame(32'hA500_0005, {4{32'h5555_AAAA}}, 0, 1'b0, 1'b0, h1, l1);
    send_frame(32'hA500_0006, {4{32'h6666_9999}}, 0, 1'b0, 1'b1, h2, l2);
    checks++;
    if (h2 != l1 + SC + 2) begin
      errors++;
      $display("FAIL back_to_back_hdr got=%0d required %0d", h2, l1 + SC + 2);
    end
    collect(6);
    check_status("back_to_back_status");
  endtask

  task automatic test_err_priority();
    int h, l;
    err_clr = 1'b1;
    send_word(32'h5A00_0002, h);
    checks++;
    if (err_sticky !== 1'b1) begin
      errors++;
      $display("FAIL err_set_wins got=%b required 1", err_sticky);
    end
    err_clr = 1'b0;
    for (int k = 0; k < NR; k++) send_word(32'h7777_0000 + k, l);
    exp_err = 1'b1;
    collect(6);
    check_status("err_priority_status");
    clear_err();
  endtask

  task automatic test_reset_strobe();
    int h, l;
    send_frame(32'hA500_0007, {4{32'h0BAD_F00D}}, 0, 1'b0, 1'b0, h, l);
    checks++;
    if (FrameStrobe !== 20'h00080) begin
      errors++;
      $display("FAIL strobe_before_reset got=%h required 00080", FrameStrobe);
    end
    resetn = 1'b0;
    #1;
    checks++;
    if (FrameStrobe !== '0 || FrameData !== '0 || s_ready !== 1'b1) begin
      errors++;
      $display("FAIL async_reset strb=%h data=%h rdy=%b required 0 0 1",
               FrameStrobe, FrameData, s_ready);
    end
    exp_fd = '0; exp_done = 16'd0; exp_err = 1'b0;
    @(negedge UserCLK); resetn = 1'b1;
    @(negedge UserCLK);
    checks++;
    if (s_ready !== 1'b1 || busy !== 1'b0 || FrameStrobe !== '0) begin
      errors++;
      $display("FAIL after_reset rdy=%b busy=%b strb=%h required 1 0 0", s_ready, busy, FrameStrobe);
    end
    check_status("after_reset_status");
    send_frame(32'hA500_0013, {32'h1234_5678, 32'h9ABC_DEF0, 32'h0F0F_0F0F, 32'hF0F0_F0F0},
               0, 1'b0, 1'b1, h, l);
    collect(6);
    check_status("post_reset_frame_status");
  endtask

`ifdef FRAME_CRC_EN
  task automatic test_crc();
    int h, l;
    send_frame(32'hA500_0002, {32'hA1A2_A3A4, 32'hB1B2_B3B4, 32'hC1C2_C3C4, 32'hD1D2_D3D4},
               0, 1'b0, 1'b1, h, l);
    collect(6);
    check_status("crc_good_status");
    send_frame(32'hA500_0004, {32'h0102_0304, 32'h0506_0708, 32'h090A_0B0C, 32'h0D0E_0F10},
               0, 1'b1, 1'b1, h, l);
    collect(6);
    check_status("crc_bad_status");
    clear_err();
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_bad_index();
    test_bad_sync();
    test_stall();
    test_back_to_back();
    test_err_priority();
    test_reset_strobe();
`ifdef FRAME_CRC_EN
    test_crc();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL global_timeout time=%0t required completion", $time);
    $fatal(1, "timeout");
  end

endmodule
